fpga_link_arbiter: RTL
======================

# fpga_link_arbiter

Round-robin arbiter and sequencer that shares one `fpga_protocol` link between `NUM_REQ` local requesters. It picks a requester and drives the link's `data_in`/`start`, then waits for `received`. It captures `data_out`, acknowledges with `processed`, waits for `busy` to drop, and returns the received byte to the requester. It sits between the local clients and the `fpga_protocol` instance and is the only driver of that instance's `data_in`, `start` and `processed` pins.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `WIDTH`, 8: link data width.
- `START_LEN`, 3: cycles `link_start` is held high.
- `PROC_LEN`, 3: cycles `link_processed` is held high.
- `TIMEOUT`, 1023: max cycles waited in WAIT_RX or WAIT_IDLE; range 1..65535.

- `clock` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in NUM_REQ: level request, held until that requester's `ack`.
- `req_data` in NUM_REQ*WIDTH: byte for requester i on [i*WIDTH +: WIDTH]; stable while `req[i]` is high.
- `grant` out NUM_REQ: one-hot, current owner; zero in IDLE.
- `ack` out NUM_REQ: one-cycle pulse, one-hot, on completion.
- `rsp_data` out WIDTH: received byte, valid in the `ack` cycle.
- `rsp_err` out 1: timeout flag, valid in the `ack` cycle.
- `link_data_in` out WIDTH: to fpga_protocol `data_in`.
- `link_start` out 1: to fpga_protocol `start`.
- `link_processed` out 1: to fpga_protocol `processed`.
- `link_busy` in 1: from fpga_protocol `busy`.
- `link_received` in 1: from fpga_protocol `received`.
- `link_data_out` in WIDTH: from fpga_protocol `data_out`.

## Operation
- All outputs are registered. Reset values: `grant`=0, `ack`=0, `rsp_data`=0, `rsp_err`=0, `link_data_in`=0, `link_start`=0, `link_processed`=0. Reset also sets state=IDLE, RR pointer=0, counters=0.
- Reset asserted in any state aborts the transfer in the same edge. Outputs drop to reset values and no `ack` is issued. The requester keeps `req` high and is re-arbitrated later.
- IDLE:
  - Arbitrate when `|req` and `link_busy`=0.
  - Winner is the first set bit searching upward from the RR pointer, wrapping from NUM_REQ-1 to 0.
  - Latch the winner into `grant`, latch `req_data[winner]` into `link_data_in`, go to START.
  - RR pointer becomes winner+1 mod NUM_REQ.
- START: `link_start`=1 for START_LEN cycles, then deassert and go to WAIT_RX. The timeout counter clears on entry.
- WAIT_RX:
  - On `link_received`=1, capture `link_data_out` into `rsp_data` and go to PROC.
  - If the counter reaches TIMEOUT first, set `rsp_err`=1 and `rsp_data`=0, and go to DONE. `link_processed` is not pulsed.
- PROC: `link_processed`=1 for PROC_LEN cycles, then deassert, clear the counter, go to WAIT_IDLE.
- WAIT_IDLE:
  - On `link_busy`=0, go to DONE.
  - On timeout, go to DONE with `rsp_err`=1; `rsp_data` keeps the captured byte.
- DONE:
  - Pulse `ack[owner]` for 1 cycle, clear `grant`, go to IDLE.
  - `rsp_err` clears on the next cycle.
  - `link_data_in` holds its value until the next grant.
- A requester that drops `req` mid-transfer does not abort it; the `ack` is still issued.
- New requests arriving during a transfer only affect the next arbitration.

## Timing
- Arbitration latency: `grant` and `link_data_in` are valid on the edge after `req` is seen high with `busy`=0 in IDLE. `link_start` rises 1 cycle later.
- `link_data_in` is stable at least 1 cycle before `link_start` rises and stays stable until the next grant.
- Total latency from `req` sampled to `ack` = 1 + START_LEN + Rx + PROC_LEN + Bz + 1 cycles, where:
  - Rx is the cycles spent in WAIT_RX, ≥1;
  - Bz is the cycles spent in WAIT_IDLE, ≥1.
- There is at least one IDLE cycle between an `ack` and the next `grant`, so back-to-back transfers are separated by ≥1 idle cycle.
- If `link_received` is already high on the first WAIT_RX cycle, it is accepted immediately (Rx=1).
- The timeout comparison counts cycles in the current state. The timeout exit occurs on cycle TIMEOUT of that state.

## Test plan
- Single request: `req`=0001, `req_data[0]`=0x01, link model echoes the byte after 20 cycles. Required: `link_start` high for 3 cycles, `link_processed` high for 3 cycles, `ack`=0001 once, `rsp_data`=0x01, `rsp_err`=0.
- Round-robin: `req`=1111 held continuously with bytes 0x11/0x22/0x44/0x88. Required: grant order 0,1,2,3,0, and each `ack` returns that requester's own byte.
- Busy gating: `link_busy`=1 while `req`=0100 is asserted. Required: `grant` stays 0 until `busy` falls, and `grant`=0100 on the following edge.
- Rx timeout with TIMEOUT=15: link never asserts `received`. Required: `ack` 1+3+15+1 cycles after the request, `rsp_err`=1, `rsp_data`=0x00, `link_processed` never high.
- Reset mid-transfer: assert `reset` during PROC. Required: all outputs 0 on the next edge and no `ack`. After `reset` drops with `req` still high, the transfer reruns and completes with the correct byte.
- Walking patterns: send 0x01, 0x02 … 0x80, 0x55, 0xAA and 0xFF through requester 2. Required: each `rsp_data` equals the byte the link model returns, with no `ack` on any other requester.

Source files
------------

// File: rtl/fpga_link_arbiter.sv
// Round-robin arbiter that shares a single fpga_protocol link between NUM_REQ requesters.
// Each transfer runs start -> wait received -> processed -> wait idle, and then acks the owner.
module fpga_link_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int WIDTH     = 8,
    parameter int START_LEN = 3,
    parameter int PROC_LEN  = 3,
    parameter int TIMEOUT   = 1023
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       ack,
    output logic [WIDTH-1:0]         rsp_data,
    output logic                     rsp_err,
    output logic [WIDTH-1:0]         link_data_in,
    output logic                     link_start,
    output logic                     link_processed,
    input  logic                     link_busy,
    input  logic                     link_received,
    input  logic [WIDTH-1:0]         link_data_out
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_START     = 3'd1;
    localparam logic [2:0] S_WAIT_RX   = 3'd2;
    localparam logic [2:0] S_PROC      = 3'd3;
    localparam logic [2:0] S_WAIT_IDLE = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    logic [2:0]           r_state;
    logic [PW-1:0]        r_ptr;
    logic [15:0]          r_cnt;
    logic [NUM_REQ-1:0]   r_grant;
    logic [NUM_REQ-1:0]   r_ack;
    logic [WIDTH-1:0]     r_rsp_data;
    logic                 r_rsp_err;
    logic [WIDTH-1:0]     r_link_data_in;
    logic                 r_link_start;
    logic                 r_link_proc;

    logic [2*NUM_REQ-1:0] w_req_dbl;
    logic [NUM_REQ-1:0]   w_req_rot;
    logic [PW-1:0]        w_off;
    logic                 w_found;
    logic [PW:0]          w_sum;
    logic [PW-1:0]        w_win;
    logic [PW-1:0]        w_ptr_next;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [WIDTH-1:0]     w_data;

    // Rotate the request vector so the RR pointer lands on bit 0, then take the lowest set bit.
    always_comb begin
        w_req_dbl = {req, req};
        w_req_rot = w_req_dbl[{1'b0, r_ptr} +: NUM_REQ];
        w_off     = '0;
        w_found   = 1'b0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!w_found && w_req_rot[i]) begin
                w_found = 1'b1;
                w_off   = PW'(i);
            end
        end
        w_sum = {1'b0, r_ptr} + {1'b0, w_off};
        if (w_sum >= (PW+1)'(NUM_REQ)) begin
            w_sum = w_sum - (PW+1)'(NUM_REQ);
        end
        w_win      = w_sum[PW-1:0];
        w_ptr_next = (w_win == PW'(NUM_REQ-1)) ? '0 : w_win + PW'(1);
    end

    always_comb begin
        w_onehot = '0;
        w_data   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_win == PW'(i)) begin
                w_onehot[i] = 1'b1;
                w_data      = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_cnt          <= '0;
            r_grant        <= '0;
            r_ack          <= '0;
            r_rsp_data     <= '0;
            r_rsp_err      <= 1'b0;
            r_link_data_in <= '0;
            r_link_start   <= 1'b0;
            r_link_proc    <= 1'b0;
        end else begin
            r_ack <= '0;
            case (r_state)
                S_IDLE: begin
                    r_rsp_err <= 1'b0;
                    if (w_found && !link_busy) begin
                        r_grant        <= w_onehot;
                        r_link_data_in <= w_data;
                        r_ptr          <= w_ptr_next;
                        r_cnt          <= '0;
                        r_state        <= S_START;
                    end
                end
                // The first START cycle only lets link_data_in settle before start rises.
                S_START: begin
                    if (r_cnt == 16'(START_LEN)) begin
                        r_link_start <= 1'b0;
                        r_cnt        <= '0;
                        r_state      <= S_WAIT_RX;
                    end else begin
                        r_link_start <= 1'b1;
                        r_cnt        <= r_cnt + 16'(1);
                    end
                end
                S_WAIT_RX: begin
                    if (link_received) begin
                        r_rsp_data  <= link_data_out;
                        r_link_proc <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_PROC;
                    end else if (r_cnt == 16'(TIMEOUT-1)) begin
                        r_rsp_err  <= 1'b1;
                        r_rsp_data <= '0;
                        r_state    <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'(1);
                    end
                end
                S_PROC: begin
                    if (r_cnt == 16'(PROC_LEN-1)) begin
                        r_link_proc <= 1'b0;
                        r_cnt       <= '0;
                        r_state     <= S_WAIT_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    if (!link_busy) begin
                        r_state <= S_DONE;
                    end else if (r_cnt == 16'(TIMEOUT-1)) begin
                        r_rsp_err <= 1'b1;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 16'(1);
                    end
                end
                S_DONE: begin
                    r_ack   <= r_grant;
                    r_grant <= '0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant          = r_grant;
    assign ack            = r_ack;
    assign rsp_data       = r_rsp_data;
    assign rsp_err        = r_rsp_err;
    assign link_data_in   = r_link_data_in;
    assign link_start     = r_link_start;
    assign link_processed = r_link_proc;

endmodule
